irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt controller between the keyboard and ethernet sources and the proc core.
- Captures source events and their 32-bit payloads, buffers ethernet payloads in a small FIFO, and prioritises between sources.
- Drives proc's interrupt_key / interrupt_eth / interrupt_source_data with a request/ack/done handshake, so only one interrupt is ever in service.

Parameters:
DATA_W, 32, width of source payload and interrupt_source_data
ETH_DEPTH, 4, ethernet payload FIFO entries (power of 2, >=2)
ETH_PRIO, 1, 1: ethernet wins simultaneous pending; 0: key wins

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
key_evt  input  1  keyboard event level; rising edge = new event
key_data  input  DATA_W  keyboard payload, sampled on key_evt rising edge
eth_valid  input  1  single-cycle ethernet payload strobe
eth_data  input  DATA_W  ethernet payload, sampled when eth_valid=1
irq_en  input  1  global interrupt enable from proc CSR
irq_ack  input  1  proc has vectored to handler; payload consumed
irq_done  input  1  proc executed handler return
interrupt_key  output  1  key interrupt request to proc
interrupt_eth  output  1  eth interrupt request to proc
interrupt_source_data  output  DATA_W  payload of presented interrupt
busy  output  1  high in REQ or SERVICE
eth_count  output  $clog2(ETH_DEPTH)+1  FIFO occupancy
key_ovf  output  1  sticky: key event lost/overwritten
eth_ovf  output  1  sticky: eth payload dropped (FIFO full)

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FIFO empty, key pending clear, edge detector history 0, state IDLE. Reset mid-handshake discards everything; no interrupt re-presented after reset.
- Clocking: all state on posedge clk.
- Key capture: registered key_evt, rising edge detect (key_evt=1 and prev=0).
  - On an edge: key_pend<=1, key_buf<=key_data.
  - Edge while key_pend=1 and not being popped this cycle: key_buf overwritten, key_ovf<=1.
- Eth capture: eth_valid=1 pushes eth_data when eth_count<ETH_DEPTH.
  - Push while full: dropped, eth_ovf<=1.
  - Simultaneous pop and push when full: pop frees a slot, push accepted, no overflow.
  - Pointers wrap modulo ETH_DEPTH.
- State machine:
  - IDLE: if irq_en=1 and (key_pend or eth_count>0), select source (both pending -> ETH_PRIO decides) and latch sel.
    - Next cycle the selected interrupt_* =1 and interrupt_source_data = key_buf or FIFO head. State -> REQ.
    - Otherwise outputs 0, data 0.
  - REQ: hold request and data stable, even if irq_en drops.
    - On irq_ack=1: pop selected source (key_pend<=0 or FIFO read), deassert interrupt_*, data<=0, -> SERVICE.
  - SERVICE: no new request. On irq_done=1 -> IDLE. Earliest next request is 1 cycle after return to IDLE (evaluated in IDLE).
  - irq_done in IDLE/REQ, irq_ack in IDLE/SERVICE: ignored.
- Latency: source event to interrupt_* asserted = 2 cycles (capture cycle + IDLE decision cycle) when idle and enabled.
- interrupt_key and interrupt_eth are never high simultaneously.
- Sticky overflow flags are cleared only by reset.

Test Plan:
- Key path: irq_en=1, key_evt 0->1 with key_data=32'hDEADBEEF -> interrupt_key=1 two cycles later with data DEADBEEF. Hold until irq_ack pulse -> interrupt_key=0 next cycle, busy stays 1. irq_done -> busy=0.
- Priority: same cycle key edge (32'h11) and eth_valid (32'h22), ETH_PRIO=1 -> eth presented first with 22. After ack+done, key presented with 11. Rerun with ETH_PRIO=0 -> order reversed.
- FIFO full/drop: irq_en=0, 5 eth strobes 1..5 -> eth_count=4, eth_ovf=1. Enable and service -> payloads 1,2,3,4 in order, count to 0.
- Full with simultaneous pop+push: FIFO full, eth_valid with 32'hA5 in the ack cycle -> eth_count stays 4, eth_ovf unchanged, A5 delivered last.
- Key overwrite: irq_en=0, two key edges with data 7 then 9 -> key_ovf=1. Enable -> single interrupt, data 9.
- Reset mid-op: assert rst_n=0 in REQ with eth_count=3 -> interrupt_eth=0 immediately (async), eth_count=0. After release with irq_en=1 -> no interrupt.

Source files
------------

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - keyboard/ethernet interrupt controller with request/ack/done handshake
module irq_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ETH_DEPTH = 4,
  parameter int ETH_PRIO  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         key_evt,
  input  logic [DATA_W-1:0]            key_data,
  input  logic                         eth_valid,
  input  logic [DATA_W-1:0]            eth_data,
  input  logic                         irq_en,
  input  logic                         irq_ack,
  input  logic                         irq_done,
  output logic                         interrupt_key,
  output logic                         interrupt_eth,
  output logic [DATA_W-1:0]            interrupt_source_data,
  output logic                         busy,
  output logic [$clog2(ETH_DEPTH):0]   eth_count,
  output logic                         key_ovf,
  output logic                         eth_ovf
);

  localparam int AW = $clog2(ETH_DEPTH);
  localparam int CW = AW + 1;
  localparam bit PRIO_ETH = (ETH_PRIO != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic               sel_eth;

  logic               key_prev;
  logic               key_pend;
  logic [DATA_W-1:0]  key_buf;
  logic               key_edge;
  logic               key_pop;

  logic [DATA_W-1:0]  eth_mem [ETH_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               eth_full;
  logic               eth_pend;
  logic               eth_pop;
  logic               eth_push;
  logic               eth_drop;
  logic               choose_eth;

  // Source event decode and pop/push qualification
  always_comb begin
    key_edge   = key_evt & ~key_prev;
    key_pop    = (state == REQ) & irq_ack & ~sel_eth;
    eth_pop    = (state == REQ) & irq_ack & sel_eth;
    eth_full   = (count == CW'(ETH_DEPTH));
    eth_pend   = (count != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted
    eth_push   = eth_valid & (~eth_full | eth_pop);
    eth_drop   = eth_valid & eth_full & ~eth_pop;
    choose_eth = eth_pend & (~key_pend | PRIO_ETH);
  end

  assign eth_count = count;
  assign busy      = (state != IDLE);

  // Keyboard edge detector, single-entry pending buffer and overwrite flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev <= 1'b0;
      key_pend <= 1'b0;
      key_buf  <= '0;
      key_ovf  <= 1'b0;
    end else begin
      key_prev <= key_evt;
      if (key_edge) begin
        key_pend <= 1'b1;
        key_buf  <= key_data;
        if (key_pend && !key_pop) key_ovf <= 1'b1;
      end else if (key_pop) begin
        key_pend <= 1'b0;
      end
    end
  end

  // Ethernet payload storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (eth_push) eth_mem[wr_ptr] <= eth_data;
  end

  // Ethernet FIFO pointers, occupancy and drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      eth_ovf <= 1'b0;
    end else begin
      if (eth_push) wr_ptr <= wr_ptr + AW'(1);
      if (eth_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({eth_push, eth_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (eth_drop) eth_ovf <= 1'b1;
    end
  end

  // Handshake FSM: one interrupt presented and serviced at a time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      sel_eth               <= 1'b0;
      interrupt_key         <= 1'b0;
      interrupt_eth         <= 1'b0;
      interrupt_source_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (irq_en && (key_pend || eth_pend)) begin
            sel_eth <= choose_eth;
            state   <= REQ;
            if (choose_eth) begin
              interrupt_eth         <= 1'b1;
              interrupt_source_data <= eth_mem[rd_ptr];
            end else begin
              interrupt_key         <= 1'b1;
              interrupt_source_data <= key_buf;
            end
          end
        end
        REQ: begin
          // Request and payload stay frozen until the core acknowledges, regardless of irq_en
          if (irq_ack) begin
            interrupt_key         <= 1'b0;
            interrupt_eth         <= 1'b0;
            interrupt_source_data <= '0;
            state                 <= SERVICE;
          end
        end
        SERVICE: begin
          if (irq_done) state <= IDLE;
        end
        default: begin
          state                 <= IDLE;
          interrupt_key         <= 1'b0;
          interrupt_eth         <= 1'b0;
          interrupt_source_data <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed testbench for irq_ctrl
module tb_irq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        key_evt;
  logic [31:0] key_data;
  logic        eth_valid;
  logic [31:0] eth_data;
  logic        irq_en;
  logic        irq_ack;
  logic        irq_done;

  logic        int_key, int_eth, busy, key_ovf, eth_ovf;
  logic [31:0] src_data;
  logic [2:0]  eth_count;

  logic        p0_int_key, p0_int_eth, p0_busy, p0_key_ovf, p0_eth_ovf;
  logic [31:0] p0_src_data;
  logic [2:0]  p0_eth_count;

  int checks;
  int passes;

  irq_ctrl #(.DATA_W(32), .ETH_DEPTH(4), .ETH_PRIO(1)) dut (
    .clk(clk), .rst_n(rst_n), .key_evt(key_evt), .key_data(key_data),
    .eth_valid(eth_valid), .eth_data(eth_data), .irq_en(irq_en),
    .irq_ack(irq_ack), .irq_done(irq_done),
    .interrupt_key(int_key), .interrupt_eth(int_eth),
    .interrupt_source_data(src_data), .busy(busy), .eth_count(eth_count),
    .key_ovf(key_ovf), .eth_ovf(eth_ovf)
  );

  irq_ctrl #(.DATA_W(32), .ETH_DEPTH(4), .ETH_PRIO(0)) dut_p0 (
    .clk(clk), .rst_n(rst_n), .key_evt(key_evt), .key_data(key_data),
    .eth_valid(eth_valid), .eth_data(eth_data), .irq_en(irq_en),
    .irq_ack(irq_ack), .irq_done(irq_done),
    .interrupt_key(p0_int_key), .interrupt_eth(p0_int_eth),
    .interrupt_source_data(p0_src_data), .busy(p0_busy), .eth_count(p0_eth_count),
    .key_ovf(p0_key_ovf), .eth_ovf(p0_eth_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic service();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({int_key, int_eth, busy, key_ovf, eth_ovf} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {int_key, int_eth, busy, key_ovf, eth_ovf});
    else passes++;
    checks++;
    if (src_data !== 32'h0 || eth_count !== 3'd0) $display("FAIL reset_data: got data=%h count=%0d expected 0/0", src_data, eth_count);
    else passes++;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({p0_int_key, p0_int_eth, p0_busy, p0_eth_count} !== 6'b0) $display("FAIL reset_p0: got %b expected 0", {p0_int_key, p0_int_eth, p0_busy, p0_eth_count});
    else passes++;
  endtask

  task automatic test_key_path();
    irq_en = 1'b1;
    key_evt = 1'b1;
    key_data = 32'hDEADBEEF;
    tick();
    checks++;
    if (int_key !== 1'b0) $display("FAIL key_latency1: got %b expected 0", int_key);
    else passes++;
    tick();
    checks++;
    if (int_key !== 1'b1 || int_eth !== 1'b0 || src_data !== 32'hDEADBEEF) $display("FAIL key_req: got k=%b e=%b data=%h expected 1 0 deadbeef", int_key, int_eth, src_data);
    else passes++;
    irq_en = 1'b0;
    tick();
    checks++;
    if (int_key !== 1'b1 || src_data !== 32'hDEADBEEF || busy !== 1'b1) $display("FAIL key_hold: got k=%b data=%h busy=%b expected 1 deadbeef 1", int_key, src_data, busy);
    else passes++;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++;
    if (int_key !== 1'b0 || src_data !== 32'h0 || busy !== 1'b1) $display("FAIL key_ack: got k=%b data=%h busy=%b expected 0 0 1", int_key, src_data, busy);
    else passes++;
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    checks++;
    if (busy !== 1'b0) $display("FAIL key_done: got busy=%b expected 0", busy);
    else passes++;
    key_evt = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    irq_en = 1'b1;
    key_evt = 1'b1;
    key_data = 32'h11;
    eth_valid = 1'b1;
    eth_data = 32'h22;
    tick();
    eth_valid = 1'b0;
    tick();
    checks++;
    if (int_eth !== 1'b1 || int_key !== 1'b0 || src_data !== 32'h22) $display("FAIL prio1_first: got e=%b k=%b data=%h expected 1 0 22", int_eth, int_key, src_data);
    else passes++;
    checks++;
    if (p0_int_key !== 1'b1 || p0_int_eth !== 1'b0 || p0_src_data !== 32'h11) $display("FAIL prio0_first: got k=%b e=%b data=%h expected 1 0 11", p0_int_key, p0_int_eth, p0_src_data);
    else passes++;
    service();
    checks++;
    if (int_key !== 1'b0 || int_eth !== 1'b0) $display("FAIL prio_gap: got k=%b e=%b expected 0 0", int_key, int_eth);
    else passes++;
    tick();
    checks++;
    if (int_key !== 1'b1 || int_eth !== 1'b0 || src_data !== 32'h11) $display("FAIL prio1_second: got k=%b e=%b data=%h expected 1 0 11", int_key, int_eth, src_data);
    else passes++;
    checks++;
    if (p0_int_eth !== 1'b1 || p0_int_key !== 1'b0 || p0_src_data !== 32'h22) $display("FAIL prio0_second: got e=%b k=%b data=%h expected 1 0 22", p0_int_eth, p0_int_key, p0_src_data);
    else passes++;
    service();
    key_evt = 1'b0;
    irq_en = 1'b0;
    tick();
  endtask

  task automatic test_fifo_full();
    irq_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      eth_valid = 1'b1;
      eth_data = i;
      tick();
    end
    eth_valid = 1'b0;
    checks++;
    if (eth_count !== 3'd4 || eth_ovf !== 1'b1) $display("FAIL fifo_full: got count=%0d ovf=%b expected 4 1", eth_count, eth_ovf);
    else passes++;
    irq_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (int_eth !== 1'b1 || src_data !== 32'(i)) $display("FAIL fifo_order%0d: got e=%b data=%h expected 1 %h", i, int_eth, src_data, 32'(i));
      else passes++;
      service();
    end
    tick();
    checks++;
    if (int_eth !== 1'b0 || eth_count !== 3'd0) $display("FAIL fifo_drained: got e=%b count=%0d expected 0 0", int_eth, eth_count);
    else passes++;
    irq_en = 1'b0;
  endtask

  task automatic test_pop_push_full();
    logic [31:0] exp_q [4];
    exp_q[0] = 32'h11; exp_q[1] = 32'h12; exp_q[2] = 32'h13; exp_q[3] = 32'hA5;
    apply_reset();
    irq_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      eth_valid = 1'b1;
      eth_data = 32'h10 + 32'(i);
      tick();
    end
    eth_valid = 1'b0;
    checks++;
    if (eth_count !== 3'd4 || eth_ovf !== 1'b0) $display("FAIL pp_filled: got count=%0d ovf=%b expected 4 0", eth_count, eth_ovf);
    else passes++;
    irq_en = 1'b1;
    tick();
    checks++;
    if (int_eth !== 1'b1 || src_data !== 32'h10) $display("FAIL pp_head: got e=%b data=%h expected 1 10", int_eth, src_data);
    else passes++;
    irq_ack = 1'b1;
    eth_valid = 1'b1;
    eth_data = 32'hA5;
    tick();
    irq_ack = 1'b0;
    eth_valid = 1'b0;
    checks++;
    if (eth_count !== 3'd4 || eth_ovf !== 1'b0) $display("FAIL pp_same_cycle: got count=%0d ovf=%b expected 4 0", eth_count, eth_ovf);
    else passes++;
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (int_eth !== 1'b1 || src_data !== exp_q[i]) $display("FAIL pp_drain%0d: got e=%b data=%h expected 1 %h", i, int_eth, src_data, exp_q[i]);
      else passes++;
      service();
    end
    checks++;
    if (eth_count !== 3'd0) $display("FAIL pp_empty: got count=%0d expected 0", eth_count);
    else passes++;
    irq_en = 1'b0;
    tick();
  endtask

  task automatic test_key_overwrite();
    irq_en = 1'b0;
    key_evt = 1'b1;
    key_data = 32'h7;
    tick();
    key_evt = 1'b0;
    checks++;
    if (key_ovf !== 1'b0) $display("FAIL kov_first: got ovf=%b expected 0", key_ovf);
    else passes++;
    tick();
    key_evt = 1'b1;
    key_data = 32'h9;
    tick();
    key_evt = 1'b0;
    checks++;
    if (key_ovf !== 1'b1 || int_key !== 1'b0) $display("FAIL kov_second: got ovf=%b k=%b expected 1 0", key_ovf, int_key);
    else passes++;
    irq_en = 1'b1;
    tick();
    checks++;
    if (int_key !== 1'b1 || src_data !== 32'h9) $display("FAIL kov_data: got k=%b data=%h expected 1 9", int_key, src_data);
    else passes++;
    service();
    tick();
    checks++;
    if (int_key !== 1'b0 || busy !== 1'b0) $display("FAIL kov_single: got k=%b busy=%b expected 0 0", int_key, busy);
    else passes++;
    irq_en = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    irq_en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      eth_valid = 1'b1;
      eth_data = 32'h100 + 32'(i);
      tick();
    end
    eth_valid = 1'b0;
    irq_en = 1'b1;
    tick();
    checks++;
    if (int_eth !== 1'b1 || eth_count !== 3'd3 || src_data !== 32'h101) $display("FAIL rst_pre: got e=%b count=%0d data=%h expected 1 3 101", int_eth, eth_count, src_data);
    else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (int_eth !== 1'b0 || eth_count !== 3'd0 || busy !== 1'b0 || src_data !== 32'h0) $display("FAIL rst_async: got e=%b count=%0d busy=%b data=%h expected 0 0 0 0", int_eth, eth_count, busy, src_data);
    else passes++;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (int_eth !== 1'b0 || int_key !== 1'b0 || busy !== 1'b0) $display("FAIL rst_after: got e=%b k=%b busy=%b expected 0 0 0", int_eth, int_key, busy);
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst_n = 1'b0;
    key_evt = 1'b0;
    key_data = '0;
    eth_valid = 1'b0;
    eth_data = '0;
    irq_en = 1'b0;
    irq_ack = 1'b0;
    irq_done = 1'b0;
    test_reset();
    test_key_path();
    test_priority();
    test_fifo_full();
    test_pop_push_full();
    test_key_overwrite();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
